date_entry: RTL and testbench

- Input-side counterpart to the birthday/seven-segment display path. The display path presents a 6-digit BCD date; this block reads a date in from the board.
- The user sets a BCD digit on sw[3:0], presses KEY0 to store it at the cursor, and presses KEY1 to commit.
- Each button input is synchronised and debounced. The block runs an edit/check state machine and validates the calendar date before committing.
- The committed date feeds the existing birthday display; the edit buffer and cursor can drive displays and LEDs.

---
 rtl/date_entry.sv | 178 +++++++++++++++++
 tb/tb_date_entry.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/date_entry.sv
// Date entry: debounced KEY0/KEY1 drive a BCD MMDDYY edit buffer, and a commit
// copies that buffer into the date output only when it holds a real calendar date.

module date_entry_deb #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_press
);
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]    r_sync;
  logic          r_stable;
  logic          r_prev;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync   <= 2'b11;
      r_stable <= 1'b1;
      r_prev   <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      r_prev <= r_stable;
      if (r_sync[1] == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
        r_stable <= r_sync[1];
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Falling edge of the debounced level only; the release edge is ignored.
  assign o_press = r_prev & ~r_stable;
endmodule

module date_entry #(
  parameter int          DEB_CYCLES = 250000,
  parameter logic [23:0] DEFAULT    = 24'h071201
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  sw,
  input  logic        b0,
  input  logic        b1,
  output logic [23:0] edit,
  output logic [23:0] date,
  output logic [2:0]  cursor,
  output logic        valid,
  output logic        done,
  output logic        err
);
  typedef enum logic {S_EDIT, S_CHECK} state_t;

  state_t      r_state, w_state_nxt;
  logic [23:0] r_edit, r_date, w_edit_nxt, w_date_nxt;
  logic [2:0]  r_cursor, w_cursor_nxt;
  logic        r_done, r_err, w_done_nxt, w_err_nxt;

  logic [1:0]  w_raw, w_press;
  logic        w_next, w_commit;

  assign w_raw = {b1, b0};

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_deb
      date_entry_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (w_raw[g]),
        .o_press(w_press[g])
      );
    end
  endgenerate

  assign w_next   = w_press[0];
  assign w_commit = w_press[1];

  logic [6:0] w_mm, w_dd, w_yy, w_maxday;
  logic       w_digits_ok, w_valid;

  assign w_mm = 7'(r_edit[23:20]) * 7'd10 + 7'(r_edit[19:16]);
  assign w_dd = 7'(r_edit[15:12]) * 7'd10 + 7'(r_edit[11:8]);
  assign w_yy = 7'(r_edit[7:4])   * 7'd10 + 7'(r_edit[3:0]);

  always_comb begin
    w_digits_ok = 1'b1;
    for (int i = 0; i < 6; i++)
      if (r_edit[4*i +: 4] > 4'd9) w_digits_ok = 1'b0;
  end

  always_comb begin
    w_maxday = 7'd0;
    case (w_mm)
      7'd1, 7'd3, 7'd5, 7'd7, 7'd8, 7'd10, 7'd12: w_maxday = 7'd31;
      7'd4, 7'd6, 7'd9, 7'd11:                    w_maxday = 7'd30;
      // Binary yy mod 4 is just its low two bits; 00 counts as a leap year.
      7'd2:    w_maxday = (w_yy[1:0] == 2'd0) ? 7'd29 : 7'd28;
      default: w_maxday = 7'd0;
    endcase
  end

  assign w_valid = w_digits_ok && (w_mm >= 7'd1) && (w_mm <= 7'd12) &&
                   (w_dd >= 7'd1) && (w_dd <= w_maxday);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_EDIT;
      r_edit   <= DEFAULT;
      r_date   <= DEFAULT;
      r_cursor <= 3'd0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_edit   <= w_edit_nxt;
      r_date   <= w_date_nxt;
      r_cursor <= w_cursor_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EDIT:  if (w_commit) w_state_nxt = S_CHECK;
      S_CHECK: w_state_nxt = S_EDIT;
      default: w_state_nxt = S_EDIT;
    endcase
  end

  always_comb begin
    w_edit_nxt   = r_edit;
    w_date_nxt   = r_date;
    w_cursor_nxt = r_cursor;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    case (r_state)
      S_EDIT: begin
        // Commit takes priority over a digit press landing in the same cycle.
        if (!w_commit && w_next) begin
          if (sw <= 4'd9) begin
            for (int i = 0; i < 6; i++)
              if (r_cursor == 3'(i)) w_edit_nxt[23-4*i -: 4] = sw;
            w_cursor_nxt = (r_cursor >= 3'd5) ? 3'd0 : r_cursor + 3'd1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_CHECK: begin
        if (w_valid) begin
          w_date_nxt   = r_edit;
          w_cursor_nxt = 3'd0;
          w_done_nxt   = 1'b1;
        end else begin
          w_err_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign edit   = r_edit;
  assign date   = r_date;
  assign cursor = r_cursor;
  assign valid  = w_valid;
  assign done   = r_done;
  assign err    = r_err;
endmodule

// File: tb/tb_date_entry.sv
// Scoreboard bench for date_entry: expected done/err pulses are queued as
// buttons are pressed and checked by a monitor when the pulses appear.
`timescale 1ns/1ps
module tb_date_entry;
  localparam logic [23:0] DEF = 24'h071201;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sw;
  logic        b0, b1;
  logic [23:0] edit, date;
  logic [2:0]  cursor;
  logic        valid, done, err;

  date_entry #(.DEB_CYCLES(4), .DEFAULT(DEF)) dut (
    .clk(clk), .rst(rst), .sw(sw), .b0(b0), .b1(b1),
    .edit(edit), .date(date), .cursor(cursor),
    .valid(valid), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [23:0] date;
    logic [23:0] edit;
    logic [2:0]  cursor;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [23:0] m_edit, m_date;
  int          m_cursor;

  function automatic bit f_valid(input logic [23:0] d);
    int mm, dd, yy, md;
    for (int i = 0; i < 6; i++) if (d[4*i +: 4] > 9) return 0;
    mm = d[23:20] * 10 + d[19:16];
    dd = d[15:12] * 10 + d[11:8];
    yy = d[7:4] * 10 + d[3:0];
    case (mm)
      1, 3, 5, 7, 8, 10, 12: md = 31;
      4, 6, 9, 11:           md = 30;
      2:                     md = (yy % 4 == 0) ? 29 : 28;
      default:               return 0;
    endcase
    return (dd >= 1) && (dd <= md);
  endfunction

  // Monitor: every done/err pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (done || err)) begin
      n_cmp++;
      if (done && err) begin
        n_err++;
        $display("FAIL pulse_exclusive: done=%b err=%b, required not both", done, err);
      end
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: done=%b err=%b, required no pulse", done, err);
      end else begin
        exp_t e;
        e = q.pop_front();
        n_cmp++;
        if (done !== e.is_done || date !== e.date || edit !== e.edit || cursor !== e.cursor) begin
          n_err++;
          $display("FAIL pulse_result: done=%b date=%h edit=%h cursor=%0d, required done=%b date=%h edit=%h cursor=%0d",
                   done, date, edit, cursor, e.is_done, e.date, e.edit, e.cursor);
        end
      end
    end
  end

  task automatic press_next(input logic [3:0] v);
    @(negedge clk);
    sw = v;
    if (v > 4'd9) q.push_back('{1'b0, m_date, m_edit, 3'(m_cursor)});
    b0 = 1'b0;
    repeat (20) @(negedge clk);
    b0 = 1'b1;
    repeat (12) @(negedge clk);
    if (v <= 4'd9) begin
      m_edit[23-4*m_cursor -: 4] = v;
      m_cursor = (m_cursor + 1) % 6;
    end
    n_cmp++;
    if (edit !== m_edit || cursor !== 3'(m_cursor)) begin
      n_err++;
      $display("FAIL digit_write: edit=%h cursor=%0d, required edit=%h cursor=%0d",
               edit, cursor, m_edit, m_cursor);
    end
  endtask

  task automatic press_commit();
    bit ok;
    ok = f_valid(m_edit);
    @(negedge clk);
    if (ok) begin
      q.push_back('{1'b1, m_edit, m_edit, 3'd0});
      m_date = m_edit;
      m_cursor = 0;
    end else begin
      q.push_back('{1'b0, m_date, m_edit, 3'(m_cursor)});
    end
    b1 = 1'b0;
    repeat (20) @(negedge clk);
    b1 = 1'b1;
    repeat (12) @(negedge clk);
    n_cmp++;
    if (date !== m_date || cursor !== 3'(m_cursor)) begin
      n_err++;
      $display("FAIL commit_state: date=%h cursor=%0d, required date=%h cursor=%0d",
               date, cursor, m_date, m_cursor);
    end
  endtask

  task automatic enter_date(input logic [23:0] d);
    for (int k = 0; k < 6; k++) press_next(d[23-4*m_cursor -: 4]);
  endtask

  task automatic goto_zero();
    while (m_cursor != 0) press_next(m_edit[23-4*m_cursor -: 4]);
  endtask

  task automatic test_reset();
    rst = 1'b1; b0 = 1'b1; b1 = 1'b1; sw = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    m_edit = DEF; m_date = DEF; m_cursor = 0;
    n_cmp++;
    if (edit !== DEF || date !== DEF || cursor !== 3'd0 || valid !== 1'b1 ||
        done !== 1'b0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: edit=%h date=%h cursor=%0d valid=%b done=%b err=%b, required %h %h 0 1 0 0",
               edit, date, cursor, valid, done, err, DEF, DEF);
    end
  endtask

  task automatic test_entry();
    enter_date(24'h120997);
    n_cmp++;
    if (valid !== 1'b1) begin
      n_err++;
      $display("FAIL valid_120997: valid=%b, required 1", valid);
    end
    press_commit();
  endtask

  task automatic test_debounce();
    @(negedge clk); b0 = 1'b0;
    repeat (2) @(negedge clk); b0 = 1'b1;
    @(negedge clk); b0 = 1'b0;
    @(negedge clk); b0 = 1'b1;
    @(negedge clk); b0 = 1'b0;
    @(negedge clk); b0 = 1'b1;
    repeat (15) @(negedge clk);
    n_cmp++;
    if (edit !== m_edit || cursor !== 3'(m_cursor)) begin
      n_err++;
      $display("FAIL glitch_ignored: edit=%h cursor=%0d, required edit=%h cursor=%0d",
               edit, cursor, m_edit, m_cursor);
    end
    sw = 4'd3; b0 = 1'b0;
    repeat (100) @(negedge clk);
    b0 = 1'b1;
    repeat (12) @(negedge clk);
    m_edit[23-4*m_cursor -: 4] = 4'd3;
    m_cursor = (m_cursor + 1) % 6;
    n_cmp++;
    if (edit !== m_edit || cursor !== 3'(m_cursor)) begin
      n_err++;
      $display("FAIL hold_one_event: edit=%h cursor=%0d, required edit=%h cursor=%0d",
               edit, cursor, m_edit, m_cursor);
    end
  endtask

  task automatic test_validation();
    goto_zero();
    enter_date(24'h023099);
    n_cmp++;
    if (valid !== 1'b0) begin
      n_err++;
      $display("FAIL valid_023099: valid=%b, required 0", valid);
    end
    press_commit();
    enter_date(24'h022900);
    press_commit();
    enter_date(24'h022999);
    press_commit();
  endtask

  task automatic test_bad_digit_and_collision();
    press_next(4'hC);
    press_next(m_edit[23-4*m_cursor -: 4]);
    // Both buttons fall together: the commit must win and no digit is written.
    @(negedge clk);
    sw = 4'd5;
    if (f_valid(m_edit)) begin
      q.push_back('{1'b1, m_edit, m_edit, 3'd0});
      m_date = m_edit; m_cursor = 0;
    end else begin
      q.push_back('{1'b0, m_date, m_edit, 3'(m_cursor)});
    end
    b0 = 1'b0; b1 = 1'b0;
    repeat (20) @(negedge clk);
    b0 = 1'b1; b1 = 1'b1;
    repeat (12) @(negedge clk);
    n_cmp++;
    if (edit !== m_edit || cursor !== 3'(m_cursor) || date !== m_date) begin
      n_err++;
      $display("FAIL commit_wins: edit=%h cursor=%0d date=%h, required edit=%h cursor=%0d date=%h",
               edit, cursor, date, m_edit, m_cursor, m_date);
    end
  endtask

  task automatic test_reset_in_check();
    enter_date(24'h031599);
    @(negedge clk);
    b1 = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1; b1 = 1'b1;
    #1;
    n_cmp++;
    if (date !== DEF || cursor !== 3'd0 || edit !== DEF || done !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_check: date=%h cursor=%0d edit=%h done=%b, required %h 0 %h 0",
               date, cursor, edit, done, DEF, DEF);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_edit = DEF; m_date = DEF; m_cursor = 0;
    repeat (30) @(negedge clk);
    n_cmp++;
    if (date !== DEF || cursor !== 3'd0) begin
      n_err++;
      $display("FAIL after_reset_check: date=%h cursor=%0d, required %h 0", date, cursor, DEF);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_entry();
    test_debounce();
    test_validation();
    test_bad_digit_and_collision();
    test_reset_in_check();
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL missing_pulses: %0d outstanding, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
